// File: rtl/data_bus_mem_slave_if.sv
// rtl/data_bus_mem_slave_if.sv - DATA_BUS request/response bundle and conf type for the SRAM responder
// Optional write-protect line present when DBUS_MEM_SLAVE_WPROT_EN is defined.

package data_bus_mem_slave_pkg;
   typedef logic [31:0] config_type;
endpackage

interface data_bus_mem_slave_if;
   import data_bus_mem_slave_pkg::*;

   logic        req;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic        err;
   logic [31:0] rdata;
   config_type  conf;
`ifdef DBUS_MEM_SLAVE_WPROT_EN
   logic        wprot;

   modport master (
      output req, addr, we, be, wdata, wprot,
      input  gnt, rvalid, err, rdata, conf
   );
   modport slave (
      input  req, addr, we, be, wdata, wprot,
      output gnt, rvalid, err, rdata, conf
   );
`else
   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, err, rdata, conf
   );
   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, err, rdata, conf
   );
`endif
endinterface

// File: rtl/data_bus_mem_slave.sv
// rtl/data_bus_mem_slave.sv - word-addressed SRAM responder on the DATA_BUS slave side
// Optional write protect: define DBUS_MEM_SLAVE_WPROT_EN to add bus.wprot.

module data_bus_mem_slave
   import data_bus_mem_slave_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter config_type  SLAVE_CONF  = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_bus_mem_slave_if.slave  bus
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [31:0] SPAN     = 32'(DEPTH) << 2;
   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] mem [DEPTH];

   logic [31:0]   offset;
   logic          hit;
   logic [AW-1:0] idx;
   logic          wprot_s;
   logic          gnt_s;
   logic          wr_en;

`ifdef DBUS_MEM_SLAVE_WPROT_EN
   assign wprot_s = bus.wprot;
`else
   assign wprot_s = 1'b0;
`endif

   // An address below BASE_ADDR wraps to a huge offset, so one unsigned compare covers both ends
   // of the window (BASE_ADDR + 4*DEPTH never wraps). BASE_ADDR is aligned, so offset[1:0] is addr[1:0].
   assign offset = bus.addr - BASE_ADDR;
   assign hit    = (offset < SPAN) && (offset[1:0] == 2'b00);
   assign idx    = offset[AW+1:2];

   // Next state, grant and response payload capture at the accept edge
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      gnt_s   = 1'b0;
      wr_en   = 1'b0;

      case (state_q)
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = state_q;
      endcase

      if (state_q != S_WAIT) begin
         gnt_s = bus.req & rst_n;
      end

      if (gnt_s) begin
         if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
         end else begin
            state_d = S_RESP;
         end
         cnt_d   = CNT_INIT;
         err_d   = ~hit | (bus.we & wprot_s);
         rdata_d = (hit && !bus.we) ? mem[idx] : 32'h0;
         wr_en   = hit & bus.we & ~wprot_s;
      end
   end

   // Control and response registers; a reset drops any pending response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Byte-enabled storage write; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.be[b]) begin
               mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
         end
      end
   end

   assign bus.gnt    = gnt_s;
   assign bus.rvalid = (state_q == S_RESP);
   assign bus.err    = (state_q == S_RESP) ? err_q : 1'b0;
   assign bus.rdata  = (state_q == S_RESP) ? rdata_q : 32'h0;
   assign bus.conf   = SLAVE_CONF;

endmodule

// File: tb/tb_data_bus_mem_slave.sv
// tb/tb_data_bus_mem_slave.sv - directed self-checking bench for data_bus_mem_slave

module tb_data_bus_mem_slave;
   import data_bus_mem_slave_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0_n, rst3_n, rst2_n;

   data_bus_mem_slave_if if0();
   data_bus_mem_slave_if if3();
   data_bus_mem_slave_if if2();

   data_bus_mem_slave #(.WAIT_CYCLES(0)) u0 (.clk(clk), .rst_n(rst0_n), .bus(if0.slave));
   data_bus_mem_slave #(.WAIT_CYCLES(3), .SLAVE_CONF(32'h1234_5678)) u3 (.clk(clk), .rst_n(rst3_n), .bus(if3.slave));
   data_bus_mem_slave #(.WAIT_CYCLES(2)) u2 (.clk(clk), .rst_n(rst2_n), .bus(if2.slave));

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input string name, input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
      vec_t v;
      v.name = name; v.we = we; v.addr = addr; v.be = be; v.wdata = wdata;
      v.exp_err = exp_err; v.exp_rdata = exp_rdata;
      vecs.push_back(v);
   endtask

   // One isolated transfer on if0 (WAIT_CYCLES=0): request, then response one cycle later
   task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                          input logic wp, output logic gnt, output logic rv, output logic err, output logic [31:0] rdata);
      @(posedge clk); #1;
      if0.req = 1'b1; if0.we = we; if0.addr = addr; if0.be = be; if0.wdata = wdata;
`ifdef DBUS_MEM_SLAVE_WPROT_EN
      if0.wprot = wp;
`endif
      @(negedge clk);
      gnt = if0.gnt;
      @(posedge clk); #1;
      if0.req = 1'b0;
`ifdef DBUS_MEM_SLAVE_WPROT_EN
      if0.wprot = 1'b0;
`endif
      @(negedge clk);
      rv = if0.rvalid; err = if0.err; rdata = if0.rdata;
   endtask

   // Eight transfers with req held; responses trail grants by exactly one cycle
   task automatic b2b(input logic we);
      int gnt_cnt = 0;
      int rv_cnt  = 0;
      for (int i = 0; i <= 8; i++) begin
         @(posedge clk); #1;
         if (i < 8) begin
            if0.req = 1'b1; if0.we = we; if0.be = 4'hF;
            if0.addr = 32'h100 + 32'(4*i);
            if0.wdata = 32'hC0DE_0000 + 32'(i);
         end else begin
            if0.req = 1'b0;
         end
         @(negedge clk);
         if (i < 8 && if0.gnt) gnt_cnt++;
         if (i > 0) begin
            if (if0.rvalid) rv_cnt++;
            if (!we) check($sformatf("b2b_rdata_%0d", i-1), if0.rdata, 32'hC0DE_0000 + 32'(i-1));
         end
      end
      check(we ? "b2b_wr_gnt_count" : "b2b_rd_gnt_count", 32'(gnt_cnt), 32'd8);
      check(we ? "b2b_wr_rv_count" : "b2b_rd_rv_count", 32'(rv_cnt), 32'd8);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        g, rv, e;
      logic [31:0] rd;
      int          lat;
      int          rv_seen;

      rst0_n = 1'b0; rst3_n = 1'b0; rst2_n = 1'b0;
      if0.req = 1'b1; if0.addr = 32'h0; if0.we = 1'b0; if0.be = 4'hF; if0.wdata = 32'h0;
      if3.req = 1'b0; if3.addr = 32'h0; if3.we = 1'b0; if3.be = 4'hF; if3.wdata = 32'h0;
      if2.req = 1'b0; if2.addr = 32'h0; if2.we = 1'b0; if2.be = 4'hF; if2.wdata = 32'h0;
`ifdef DBUS_MEM_SLAVE_WPROT_EN
      if0.wprot = 1'b0; if3.wprot = 1'b0; if2.wprot = 1'b0;
`endif

      // Reset state, gnt masked while in reset even with req high
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", 32'(if0.gnt), 32'd0);
      check("rst_rvalid", 32'(if0.rvalid), 32'd0);
      check("rst_err", 32'(if0.err), 32'd0);
      check("rst_rdata", if0.rdata, 32'h0);
      check("conf_default", if0.conf, 32'h0);
      check("conf_param", if3.conf, 32'h1234_5678);
      @(posedge clk); #1;
      if0.req = 1'b0;
      rst0_n = 1'b1; rst3_n = 1'b1; rst2_n = 1'b1;

      add_vec("wr_10",        1'b1, 32'h0000_0010, 4'hF,    32'hDEAD_BEEF, 1'b0, 32'h0);
      add_vec("rd_10",        1'b0, 32'h0000_0010, 4'hF,    32'h0,         1'b0, 32'hDEAD_BEEF);
      add_vec("wr_10_part",   1'b1, 32'h0000_0010, 4'b0101, 32'h1122_3344, 1'b0, 32'h0);
      add_vec("rd_10_part",   1'b0, 32'h0000_0010, 4'hF,    32'h0,         1'b0, 32'hDE22_BE44);
      add_vec("wr_00",        1'b1, 32'h0000_0000, 4'hF,    32'hA5A5_A5A5, 1'b0, 32'h0);
      add_vec("rd_402_mis",   1'b0, 32'h0000_0402, 4'hF,    32'h0,         1'b1, 32'h0);
      add_vec("rd_400_end",   1'b0, 32'h0000_0400, 4'hF,    32'h0,         1'b1, 32'h0);
      add_vec("wr_400_miss",  1'b1, 32'h0000_0400, 4'hF,    32'hFFFF_FFFF, 1'b1, 32'h0);
      add_vec("wr_12_mis",    1'b1, 32'h0000_0012, 4'hF,    32'h0,         1'b1, 32'h0);
      add_vec("rd_00_intact", 1'b0, 32'h0000_0000, 4'hF,    32'h0,         1'b0, 32'hA5A5_A5A5);
      add_vec("rd_10_intact", 1'b0, 32'h0000_0010, 4'hF,    32'h0,         1'b0, 32'hDE22_BE44);
      add_vec("wr_3fc",       1'b1, 32'h0000_03FC, 4'hF,    32'h0102_0304, 1'b0, 32'h0);
      add_vec("wr_3fc_b3",    1'b1, 32'h0000_03FC, 4'b1000, 32'h77FF_FFFF, 1'b0, 32'h0);
      add_vec("rd_3fc",       1'b0, 32'h0000_03FC, 4'hF,    32'h0,         1'b0, 32'h7702_0304);
      add_vec("wr_10_be0",    1'b1, 32'h0000_0010, 4'h0,    32'h0,         1'b0, 32'h0);
      add_vec("rd_10_be0",    1'b0, 32'h0000_0010, 4'hF,    32'h0,         1'b0, 32'hDE22_BE44);
      add_vec("rd_far_miss",  1'b0, 32'h8000_0000, 4'hF,    32'h0,         1'b1, 32'h0);

      foreach (vecs[i]) begin
         do_xfer(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, 1'b0, g, rv, e, rd);
         check({vecs[i].name, "_gnt"}, 32'(g), 32'd1);
         check({vecs[i].name, "_rvalid"}, 32'(rv), 32'd1);
         check({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].exp_err));
         check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      end

      // rdata/err held at zero outside rvalid
      @(negedge clk);
      check("idle_rvalid", 32'(if0.rvalid), 32'd0);
      check("idle_rdata", if0.rdata, 32'h0);
      check("idle_err", 32'(if0.err), 32'd0);

`ifdef DBUS_MEM_SLAVE_WPROT_EN
      do_xfer(1'b1, 32'h0000_0010, 4'hF, 32'h0BAD_0BAD, 1'b1, g, rv, e, rd);
      check("wprot_err", 32'(e), 32'd1);
      check("wprot_rdata", rd, 32'h0);
      do_xfer(1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b1, g, rv, e, rd);
      check("wprot_rd_err", 32'(e), 32'd0);
      check("wprot_readback", rd, 32'hDE22_BE44);
`endif

      b2b(1'b1);
      b2b(1'b0);

      // WAIT_CYCLES=3: accept at cycle 0, rvalid at cycle 4, req held throughout
      @(posedge clk); #1;
      if3.req = 1'b1; if3.we = 1'b0; if3.addr = 32'h0000_0001;
      @(negedge clk);
      check("w3_c0_gnt", 32'(if3.gnt), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("w3_c%0d_gnt", k), 32'(if3.gnt), 32'(k == 4));
         check($sformatf("w3_c%0d_rvalid", k), 32'(if3.rvalid), 32'(k == 4));
      end
      check("w3_err", 32'(if3.err), 32'd1);
      check("w3_rdata", if3.rdata, 32'h0);
      @(posedge clk); #1;
      if3.req = 1'b0;
      for (int k = 5; k <= 8; k++) begin
         if (k > 5) @(posedge clk);
         @(negedge clk);
         check($sformatf("w3_c%0d_rvalid2", k), 32'(if3.rvalid), 32'(k == 8));
      end

      // WAIT_CYCLES=2: reset while a response is pending
      @(posedge clk); #1;
      if2.req = 1'b1; if2.we = 1'b0; if2.addr = 32'h0000_0002;
      @(negedge clk);
      check("w2_gnt", 32'(if2.gnt), 32'd1);
      @(posedge clk); #1;
      if2.req = 1'b0;
      @(posedge clk); #1;
      rst2_n = 1'b0;
      if2.req = 1'b1;
      @(negedge clk);
      check("w2_rst_gnt", 32'(if2.gnt), 32'd0);
      check("w2_rst_rvalid", 32'(if2.rvalid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("w2_rst_gnt2", 32'(if2.gnt), 32'd0);
      @(posedge clk); #1;
      rst2_n = 1'b1;
      if2.req = 1'b0;
      rv_seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (if2.rvalid) rv_seen++;
      end
      check("w2_no_stale_rvalid", 32'(rv_seen), 32'd0);

      @(posedge clk); #1;
      if2.req = 1'b1; if2.addr = 32'h0000_0002;
      @(negedge clk);
      check("w2_post_gnt", 32'(if2.gnt), 32'd1);
      @(posedge clk); #1;
      if2.req = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (if2.rvalid) begin
            lat = k;
            break;
         end
         @(posedge clk);
      end
      check("w2_post_latency", 32'(lat), 32'd3);
      check("w2_post_err", 32'(if2.err), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
